// File: rtl/mem_writeback.sv
`default_nettype none
// ============================================================================
// Module   : mem_writeback
// Purpose  : Writeback stage that follows the load/store execute stage.
//            Stage A holds the instruction while the data memory returns its
//            1-cycle-latency read data. The combinational select then picks
//            the load data or the ALU result. Stage B registers the
//            register-file write port, which also serves as the forwarding
//            entry. The block also provides load-use stall detection toward
//            decode and a retired-instruction counter.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_*                - instruction leaving execute this cycle
//            mem_q               - data memory read data (1 cycle after issue)
//            flush               - kill the entry being captured into stage A
//            dec_*               - decode-stage source operands for stall check
//            stall               - load-use hazard, decode must hold
//            rf_we/waddr/wdata   - register-file write port
//            fwd_valid/idx/data  - forwarding entry (same registers as rf_*)
//            retired             - retired-instruction count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module mem_writeback #(
    parameter int REG_IDX_W = 5,
    parameter int DATA_W    = 32,
    parameter int RET_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_load,
    input  logic                 in_store,
    input  logic [REG_IDX_W-1:0] in_rd_idx,
    input  logic [DATA_W-1:0]    in_alu_result,
    input  logic [DATA_W-1:0]    mem_q,
    input  logic                 flush,
    input  logic                 dec_valid,
    input  logic [REG_IDX_W-1:0] dec_rs_idx,
    input  logic [REG_IDX_W-1:0] dec_rt_idx,
    output logic                 stall,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 fwd_valid,
    output logic [REG_IDX_W-1:0] fwd_idx,
    output logic [DATA_W-1:0]    fwd_data,
    output logic [RET_W-1:0]     retired
);

    localparam logic [REG_IDX_W-1:0] c_ZERO_IDX = '0;
    localparam logic [RET_W-1:0]     c_RET_ONE  = RET_W'(1);

    // Stage A
    logic                 a_valid_q, a_valid_d;
    logic                 a_load_q,  a_load_d;
    logic                 a_store_q, a_store_d;
    logic [REG_IDX_W-1:0] a_rd_q,    a_rd_d;
    logic [DATA_W-1:0]    a_alu_q,   a_alu_d;

    // Stage B / register-file write port
    logic                 rf_we_q,    rf_we_d;
    logic [REG_IDX_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]    rf_wdata_q, rf_wdata_d;

    logic [RET_W-1:0]     retired_q,  retired_d;

    logic                 w_load_cand;
    logic                 w_wb_we;
    logic [DATA_W-1:0]    w_wb_data;

    // A store that also flags a load is treated purely as a store.
    assign w_load_cand = in_load & ~in_store;

    always_comb begin
        a_valid_d = in_valid & ~flush;
        a_load_d  = w_load_cand;
        a_store_d = in_store;
        a_rd_d    = in_rd_idx;
        a_alu_d   = in_alu_result;

        // mem_q belongs to the load that sits in stage A this cycle.
        w_wb_data = a_load_q ? mem_q : a_alu_q;
        w_wb_we   = a_valid_q & ~a_store_q & (a_rd_q != c_ZERO_IDX);

        // Address and data hold when no write occurs so the forwarding
        // entry keeps the last written value.
        rf_we_d    = w_wb_we;
        rf_waddr_d = w_wb_we ? a_rd_q    : rf_waddr_q;
        rf_wdata_d = w_wb_we ? w_wb_data : rf_wdata_q;

        // Stores and writes to register 0 still retire.
        retired_d  = a_valid_q ? (retired_q + c_RET_ONE) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q  <= 1'b0;
            a_load_q   <= 1'b0;
            a_store_q  <= 1'b0;
            a_rd_q     <= '0;
            a_alu_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            retired_q  <= '0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_load_q   <= a_load_d;
            a_store_q  <= a_store_d;
            a_rd_q     <= a_rd_d;
            a_alu_q    <= a_alu_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            retired_q  <= retired_d;
        end
    end

    // The load in execute produces its data one cycle too late for a
    // dependent instruction in decode. Flush is deliberately not considered
    // here; the flush path takes priority further downstream.
    assign stall = in_valid & w_load_cand & dec_valid & (in_rd_idx != c_ZERO_IDX) &
                   ((dec_rs_idx == in_rd_idx) | (dec_rt_idx == in_rd_idx));

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign fwd_valid = rf_we_q;
    assign fwd_idx   = rf_waddr_q;
    assign fwd_data  = rf_wdata_q;
    assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_writeback
// Purpose  : Self-checking bench for mem_writeback. It uses directed steps
//            followed by randomized traffic. The results are checked against
//            a reference model of in-flight instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 0, in_load = 0, in_store = 0, flush = 0, dec_valid = 0;
    logic [4:0]  in_rd_idx = 0, dec_rs_idx = 0, dec_rt_idx = 0;
    logic [31:0] in_alu_result = 0, mem_q = 0;
    logic        stall, rf_we, fwd_valid;
    logic [4:0]  rf_waddr, fwd_idx;
    logic [31:0] rf_wdata, fwd_data, retired;

    int n_assert = 0;
    int n_fail   = 0;

    mem_writeback #(.REG_IDX_W(5), .DATA_W(32), .RET_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
        .in_rd_idx(in_rd_idx), .in_alu_result(in_alu_result), .mem_q(mem_q),
        .flush(flush), .dec_valid(dec_valid),
        .dec_rs_idx(dec_rs_idx), .dec_rt_idx(dec_rt_idx),
        .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // Reference model: one pending instruction waiting for memory data,
    // plus the architecturally visible write port and retire count.
    typedef struct {
        bit          valid;
        bit          load;
        bit          store;
        int unsigned rd;
        logic [31:0] alu;
    } instr_t;

    instr_t      pend;
    bit          m_we;
    int unsigned m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_ret;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend    = '{0, 0, 0, 0, 32'h0};
        m_we    = 0;
        m_waddr = 0;
        m_wdata = 32'h0;
        m_ret   = 32'h0;
    endtask

    // One clock cycle: drive inputs, check stall mid-cycle, advance the
    // model at the edge, then check the registered outputs.
    task automatic step(input bit v, input bit ld, input bit st, input int unsigned rd,
                        input logic [31:0] alu, input logic [31:0] mq, input bit fl,
                        input bit dv, input int unsigned rs, input int unsigned rt);
        bit exp_stall;
        in_valid = v; in_load = ld; in_store = st; in_rd_idx = rd[4:0];
        in_alu_result = alu; mem_q = mq; flush = fl;
        dec_valid = dv; dec_rs_idx = rs[4:0]; dec_rt_idx = rt[4:0];
        #2;
        exp_stall = v && ld && !st && dv && rd != 0 && (rs == rd || rt == rd);
        chk("stall", {63'b0, stall}, {63'b0, exp_stall});
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (pend.valid) m_ret = m_ret + 1;
            if (pend.valid && !pend.store && pend.rd != 0) begin
                m_we    = 1;
                m_waddr = pend.rd;
                m_wdata = pend.load ? mq : pend.alu;
            end else begin
                m_we = 0;
            end
            pend = '{v && !fl, ld && !st, st, rd, alu};
        end
        #1;
        chk("rf_we",     {63'b0, rf_we},     {63'b0, m_we});
        chk("rf_waddr",  {59'b0, rf_waddr},  64'(m_waddr));
        chk("rf_wdata",  {32'b0, rf_wdata},  {32'b0, m_wdata});
        chk("fwd_valid", {63'b0, fwd_valid}, {63'b0, m_we});
        chk("fwd_idx",   {59'b0, fwd_idx},   64'(m_waddr));
        chk("fwd_data",  {32'b0, fwd_data},  {32'b0, m_wdata});
        chk("retired",   {32'b0, retired},   {32'b0, m_ret});
    endtask

    task automatic idle(input logic [31:0] mq);
        step(0, 0, 0, 0, 32'h0, mq, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] ret0;
        model_reset();

        // Reset and idle
        rst = 1;
        idle(32'h0);
        idle(32'h0);
        rst = 0;
        idle(32'h0);
        chk("reset_we",    {63'b0, rf_we}, 64'h0);
        chk("reset_ret",   {32'b0, retired}, 64'h0);
        chk("reset_waddr", {59'b0, rf_waddr}, 64'h0);
        chk("reset_wdata", {32'b0, rf_wdata}, 64'h0);

        // ALU op to r5
        step(1, 0, 0, 5, 32'h1234_5678, 32'h0, 0, 0, 0, 0);
        idle(32'hAAAA_AAAA);
        chk("alu_we",    {63'b0, rf_we}, 64'h1);
        chk("alu_waddr", {59'b0, rf_waddr}, 64'h5);
        chk("alu_wdata", {32'b0, rf_wdata}, 64'h1234_5678);
        chk("alu_ret",   {32'b0, retired}, 64'h1);
        idle(32'h0);
        chk("alu_pulse", {63'b0, rf_we}, 64'h0);

        // Load to r7, data arrives the following cycle
        step(1, 1, 0, 7, 32'h5555_0000, 32'h0BAD_0BAD, 0, 0, 0, 0);
        idle(32'hDEAD_BEEF);
        chk("ld_waddr", {59'b0, rf_waddr}, 64'h7);
        chk("ld_wdata", {32'b0, rf_wdata}, 64'hDEAD_BEEF);
        idle(32'h0BAD_0BAD);
        chk("ld_hold", {32'b0, rf_wdata}, 64'hDEAD_BEEF);

        // Store to r3, then ALU to r0: no writes, two retirements
        ret0 = retired;
        step(1, 0, 1, 3, 32'h1111_1111, 32'h0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 32'h2222_2222, 32'h0, 0, 0, 0, 0);
        idle(32'h0);
        idle(32'h0);
        chk("st_r0_ret", {32'b0, retired}, {32'b0, ret0 + 32'd2});

        // Load-use stall cases
        step(1, 1, 0, 9, 32'h0, 32'h0, 0, 1, 1, 9);
        step(1, 1, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0);
        step(1, 1, 0, 9, 32'h0, 32'h0, 0, 1, 4, 4);
        idle(32'h0);
        idle(32'h0);

        // Flushed ALU op does not write or retire
        ret0 = retired;
        step(1, 0, 0, 6, 32'h6666_6666, 32'h0, 1, 0, 0, 0);
        idle(32'h0);
        idle(32'h0);
        chk("flush_ret", {32'b0, retired}, {32'b0, ret0});

        // Reset right after a valid load
        step(1, 1, 0, 7, 32'h0, 32'h0, 0, 0, 0, 0);
        rst = 1;
        idle(32'hFEED_FACE);
        rst = 0;
        idle(32'h0);
        idle(32'h0);
        chk("rst_ret", {32'b0, retired}, 64'h0);
        chk("rst_we",  {63'b0, rf_we}, 64'h0);

        // Random traffic, including back-to-back writes and occasional reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 7), $urandom, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7));
        end
        rst = 0;
        idle(32'h0);
        idle(32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
